// File: rtl/soin_pkg.sv
// Shared SOIN-RV datapath constants used by the core and its memories.
package soin_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned DMEM_DEPTH = 256;

endpackage : soin_pkg

// File: rtl/data_memory.sv
// Word-organised data RAM for the load/store stage: synchronous word writes,
// combinational word reads, flop storage cleared asynchronously by rst.
module data_memory
  import soin_pkg::*;
#(
  parameter int unsigned DEPTH   = DMEM_DEPTH,
  parameter int unsigned INDEX_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] Rd,
  input  logic [XLEN-1:0] Wd,
  input  logic [XLEN-1:0] Addr,
  input  logic            Wen,
  input  logic            Ren
);

  localparam int unsigned LSB_W = 2;
  localparam int unsigned HI_W  = XLEN - INDEX_W - LSB_W;

  logic [XLEN-1:0]    mem [DEPTH];
  logic [INDEX_W-1:0] index;
  logic               in_range;
  logic               unused_byte_offset;

  // Upper address bits must be zero; otherwise the access would alias a low word.
  function automatic logic addr_in_range(input logic [HI_W-1:0] hi);
    return hi == HI_W'(0);
  endfunction

  assign index              = Addr[INDEX_W+LSB_W-1:LSB_W];
  assign in_range           = addr_in_range(Addr[XLEN-1:INDEX_W+LSB_W]);
  assign unused_byte_offset = ^Addr[LSB_W-1:0];

  // Array write; an X or 0 on Wen fails the equality test and leaves storage alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if ((Wen == 1'b1) && in_range) begin
      mem[index] <= Wd;
    end
  end

  assign Rd = (!rst && Ren && in_range) ? mem[index] : XLEN'(0);

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: expected read data is queued as each read
// is driven and popped when Rd is sampled.
module tb_data_memory;
  import soin_pkg::*;

  typedef struct {
    string           tag;
    logic [XLEN-1:0] exp;
  } sb_entry_t;

  logic            clk;
  logic            rst;
  logic [XLEN-1:0] Rd;
  logic [XLEN-1:0] Wd;
  logic [XLEN-1:0] Addr;
  logic            Wen;
  logic            Ren;

  sb_entry_t sb_q[$];
  int        n_checks;
  int        n_pass;

  data_memory #(.DEPTH(256)) dut (
    .clk  (clk),
    .rst  (rst),
    .Rd   (Rd),
    .Wd   (Wd),
    .Addr (Addr),
    .Wen  (Wen),
    .Ren  (Ren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic sb_push(input string tag, input logic [XLEN-1:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check();
    sb_entry_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard_empty: got no entry expected one");
    end else begin
      e = sb_q.pop_front();
      check(e.tag, Rd, e.exp);
    end
  endtask

  task automatic wr(input logic [XLEN-1:0] a, input logic [XLEN-1:0] d);
    @(negedge clk);
    Addr = a; Wd = d; Wen = 1'b1; Ren = 1'b0;
    @(posedge clk);
    #1;
    Wen = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [XLEN-1:0] a, input logic ren,
                    input logic [XLEN-1:0] exp);
    @(negedge clk);
    Addr = a; Ren = ren; Wen = 1'b0;
    sb_push(tag, exp);
    #1;
    sb_pop_check();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; Wen = 1'b0; Ren = 1'b1; Addr = '0; Wd = '0;

    // Reset held for two cycles; Rd must stay 0 throughout.
    repeat (2) @(posedge clk);
    #1;
    sb_push("rd_during_rst", 32'h0);
    sb_pop_check();
    @(negedge clk);
    rst = 1'b0;

    rd("rst_0x000", 32'h000, 1'b1, 32'h0);
    rd("rst_0x004", 32'h004, 1'b1, 32'h0);
    rd("rst_0x3fc", 32'h3FC, 1'b1, 32'h0);

    wr(32'h010, 32'hDEADBEEF);
    wr(32'h3FC, 32'h12345678);
    rd("wr_0x010", 32'h010, 1'b1, 32'hDEADBEEF);
    rd("wr_0x3fc", 32'h3FC, 1'b1, 32'h12345678);
    rd("unwritten_0x014", 32'h014, 1'b1, 32'h0);

    rd("unaligned_0x013", 32'h013, 1'b1, 32'hDEADBEEF);
    rd("ren_low_0x010", 32'h010, 1'b0, 32'h0);

    // Wen low with all-ones data must not disturb the word.
    @(negedge clk);
    Addr = 32'h010; Wd = 32'hFFFFFFFF; Wen = 1'b0;
    @(posedge clk);
    rd("wen_low_keep", 32'h010, 1'b1, 32'hDEADBEEF);

    wr(32'h000, 32'hA5A5A5A5);
    wr(32'h400, 32'hCAFEF00D);
    rd("oor_rd_0x400", 32'h400, 1'b1, 32'h0);
    rd("no_alias_0x000", 32'h000, 1'b1, 32'hA5A5A5A5);
    wr(32'h8000_0010, 32'h0BADF00D);
    rd("no_alias_hi_0x010", 32'h010, 1'b1, 32'hDEADBEEF);

    // Same-cycle read and write: old word before the edge, new word after.
    wr(32'h020, 32'h11111111);
    @(negedge clk);
    Addr = 32'h020; Wd = 32'h22222222; Wen = 1'b1; Ren = 1'b1;
    sb_push("rw_before_edge", 32'h11111111);
    #1;
    sb_pop_check();
    @(posedge clk);
    #1;
    Wen = 1'b0;
    sb_push("rw_after_edge", 32'h22222222);
    sb_pop_check();

    for (int i = 0; i < 16; i++) wr(XLEN'(i * 4), 32'h1000_0000 | XLEN'(i + 1));
    rd("fill_0x03c", 32'h03C, 1'b1, 32'h1000_0010);

    // Asynchronous reset pulse between edges clears Rd without a clock.
    #1;
    rst = 1'b1;
    #1;
    sb_push("rst_async_rd", 32'h0);
    sb_pop_check();
    Addr = 32'h008; Wd = 32'h0000_0BAD; Wen = 1'b1;
    @(posedge clk);
    #1;
    check("rst_blocks_wr_rd", Rd, 32'h0);
    @(negedge clk);
    Wen = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) rd($sformatf("post_rst_%02h", i * 4), XLEN'(i * 4), 1'b1, 32'h0);
    rd("post_rst_0x010", 32'h010, 1'b1, 32'h0);
    rd("post_rst_0x3fc", 32'h3FC, 1'b1, 32'h0);

    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_data_memory

// File: doc/data_memory.md
# data_memory

Word-organised data RAM (`DATA_MEMORY`) for the SOIN-RV datapath, serving the load/store stage. It takes a 32-bit byte address from the ALU and a 32-bit store value from the register file. Stores are written synchronously on the clock edge. Loads return the addressed word combinationally in the same cycle.

## Interface
Parameters:
- `DEPTH`, default 256: number of 32-bit words; must be a power of two, 2 to 4096.
- `INDEX_W`, default `$clog2(DEPTH)`: word-index width; derived, not overridden.

Ports:
- `clk`, input, 1: single clock. All writes occur on its rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `Rd`, output, 32: read data.
- `Wd`, input, 32: write data.
- `Addr`, input, 32: byte address.
- `Wen`, input, 1: write enable.
- `Ren`, input, 1: read enable.

## Operation
- Storage is `DEPTH` words of 32 bits, implemented in flops so reset can clear it.
- Word index is `Addr[INDEX_W+1:2]`.
- `Addr[1:0]` is ignored. Accesses are word-aligned only; no byte or halfword lanes.
- In range means `Addr[31:INDEX_W+2] == 0`. Any other address is out of range.
- Write: on rising `clk`, with `Wen`=1, `rst`=0 and an in-range address, `mem[index]` <= `Wd`.
  - An out-of-range write is silently dropped. No other word changes.
- Read: `Rd = mem[index]` when `Ren`=1 and the address is in range. Otherwise `Rd = 32'h0`.
- `Ren` only gates the output. It never affects storage.
- Reset: while `rst`=1, every word is 0, `Rd` is 0, and writes are blocked.
- Reset asserted in the middle of operation clears the whole array immediately, with no clock edge required.
- `Wen` and `Ren` both high, same address: before the edge, `Rd` shows the old word. After the edge, it shows `Wd`. No write-through bypass.
- X on `Wen` must never corrupt storage. Treat non-1 as no write; synthesis is unaffected.

## Timing
- Read latency is 0 cycles: `Rd` is purely combinational from `Addr`, `Ren` and the array.
- Write latency is 1 edge: data is visible on `Rd` in the cycle after the write edge.
- Reset assertion is asynchronous. Release is sampled at the next rising `clk`; the first write can occur on the first edge with `rst`=0.
- No handshake and no stall: every cycle accepts one read and one write.
- After reset, all outputs are 0. Before any write, every in-range read returns 0.

## Structure
- The shared package `soin_pkg` holds `XLEN`=32 and `DMEM_DEPTH` default 256. The core references these and passes the depth to `DEPTH`.
- Single module, no sub-modules. The address decode (index plus in-range flag) may be a local function.
- Array write: one `always` block on `posedge clk or posedge rst`. Read mux: one `assign`.

## Test plan
- Reset: assert `rst` for 2 cycles, then read `Addr`=0x0, 0x4 and 0x3FC with `Ren`=1 -> `Rd`=0x00000000 each.
- Write/read-back: write 0xDEADBEEF at 0x10 and 0x12345678 at 0x3FC. Then read both -> exact values. A read of 0x14 -> 0.
- Alignment and gating:
  - read 0x13 after writing 0x10 -> 0xDEADBEEF;
  - the same with `Ren`=0 -> 0;
  - `Wen`=0 with `Wd`=0xFFFFFFFF at 0x10 -> word unchanged.
- Out-of-range, with `DEPTH`=256:
  - write 0xCAFEF00D at 0x400 -> reading 0x400 gives 0;
  - reading 0x0 still gives its prior value (no aliasing).
- Same-cycle read/write at 0x20: old 0x11111111, new 0x22222222.
  - `Rd`=0x11111111 before the edge, 0x22222222 after it.
- Reset mid-operation: fill 0x0 to 0x3C with nonzero data, then pulse `rst` between clock edges.
  - `Rd` goes 0 immediately.
  - All words read 0 afterwards.
  - A `Wen` asserted during `rst` has no effect.
